// File: rtl/codes.sv
// Shared types for the core-to-memory path: data word, access size and
// master FSM state encodings.
package codes;

  typedef logic [31:0] size_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: byteenable and write data placement,
// misalignment detection, and load lane extraction with extension.
module mem_lane_align
  import codes::*;
(
  input  logic [1:0] offset,
  input  mem_size_t  size,
  input  logic       sgn,
  input  size_t      wdata,
  input  size_t      rdata,
  output logic [3:0] byteenable,
  output size_t      wdata_lane,
  output logic       misaligned,
  output size_t      rdata_ext
);

  size_t lane;

  always_comb begin
    lane       = rdata >> {offset, 3'b000};
    byteenable = 4'b1111;
    wdata_lane = wdata;
    misaligned = 1'b0;
    rdata_ext  = lane;
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << offset;
        wdata_lane = {24'd0, wdata[7:0]} << {offset, 3'b000};
        rdata_ext  = {{24{sgn & lane[7]}}, lane[7:0]};
      end
      SIZE_HALF: begin
        byteenable = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {16'd0, wdata[15:0]} << {offset[1], 4'b0000};
        misaligned = offset[0];
        rdata_ext  = {{16{sgn & lane[15]}}, lane[15:0]};
      end
      default: begin
        // unused encoding 3 is treated as a word access
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/avalon_mem_master.sv
// Single-outstanding Avalon-MM style initiator for core byte/half/word
// loads and stores, with one-cycle response pulse back to the core.
//
// state | meaning
// IDLE  | ready for a core request
// BUS   | strobe on the bus, held while waitrequest is high
// RDATA | read accepted; readdata is captured at the end of this cycle
// RESP  | resp_valid pulse to the core
module avalon_mem_master
  import codes::*;
#(
  parameter size_t ADDR_MASK = 32'hFFFFFFFC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  mem_size_t  req_size,
  input  logic       req_signed,
  input  size_t      req_addr,
  input  size_t      req_wdata,
  output logic       resp_valid,
  output size_t      resp_rdata,
  output logic       resp_error,
  output size_t      address,
  output logic       read,
  output logic       write,
  output logic [3:0] byteenable,
  output size_t      writedata,
  input  size_t      readdata,
  input  logic       waitrequest
);

  mem_state_t state, state_nxt;
  logic [1:0] off_q, off_nxt;
  mem_size_t  size_q, size_nxt;
  logic       sgn_q, sgn_nxt;
  logic       read_nxt, write_nxt, resp_valid_nxt, resp_error_nxt;
  size_t      resp_rdata_nxt, address_nxt, writedata_nxt;
  logic [3:0] byteenable_nxt;

  logic [1:0] al_off;
  mem_size_t  al_size;
  logic       al_sgn, al_mis;
  logic [3:0] al_be;
  size_t      al_wdata, al_rdata;

  // the aligner sees the live request in IDLE and the latched one afterwards
  assign al_off    = (state == IDLE) ? req_addr[1:0] : off_q;
  assign al_size   = (state == IDLE) ? req_size : size_q;
  assign al_sgn    = (state == IDLE) ? req_signed : sgn_q;
  assign req_ready = (state == IDLE);

  mem_lane_align u_align (
    .offset     (al_off),
    .size       (al_size),
    .sgn        (al_sgn),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .byteenable (al_be),
    .wdata_lane (al_wdata),
    .misaligned (al_mis),
    .rdata_ext  (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      off_q      <= 2'd0;
      size_q     <= SIZE_BYTE;
      sgn_q      <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      address    <= '0;
      byteenable <= 4'd0;
      writedata  <= '0;
    end else begin
      state      <= state_nxt;
      off_q      <= off_nxt;
      size_q     <= size_nxt;
      sgn_q      <= sgn_nxt;
      read       <= read_nxt;
      write      <= write_nxt;
      resp_valid <= resp_valid_nxt;
      resp_error <= resp_error_nxt;
      resp_rdata <= resp_rdata_nxt;
      address    <= address_nxt;
      byteenable <= byteenable_nxt;
      writedata  <= writedata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    off_nxt        = off_q;
    size_nxt       = size_q;
    sgn_nxt        = sgn_q;
    read_nxt       = read;
    write_nxt      = write;
    resp_valid_nxt = 1'b0;
    resp_error_nxt = resp_error;
    resp_rdata_nxt = resp_rdata;
    address_nxt    = address;
    byteenable_nxt = byteenable;
    writedata_nxt  = writedata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          resp_rdata_nxt = '0;
          if (al_mis) begin
            resp_error_nxt = 1'b1;
            resp_valid_nxt = 1'b1;
            state_nxt      = RESP;
          end else begin
            resp_error_nxt = 1'b0;
            off_nxt        = req_addr[1:0];
            size_nxt       = req_size;
            sgn_nxt        = req_signed;
            address_nxt    = req_addr & ADDR_MASK;
            byteenable_nxt = al_be;
            writedata_nxt  = al_wdata;
            read_nxt       = ~req_write;
            write_nxt      = req_write;
            state_nxt      = BUS;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          if (write) begin
            resp_valid_nxt = 1'b1;
            state_nxt      = RESP;
          end else begin
            state_nxt = RDATA;
          end
        end
      end
      RDATA: begin
        resp_rdata_nxt = al_rdata;
        resp_valid_nxt = 1'b1;
        state_nxt      = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_mem_master.sv
// Randomized bench for avalon_mem_master: byte-level memory model checked
// against a word RAM responder driven by the DUT's bus.
module tb_avalon_mem_master;
  import codes::*;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  mem_size_t  req_size = SIZE_BYTE;
  size_t      req_addr = '0, req_wdata = '0;
  logic       resp_valid, resp_error;
  size_t      resp_rdata, address, writedata;
  logic       read, write, waitrequest = 1'b0;
  logic [3:0] byteenable;
  size_t      readdata = '0;

  avalon_mem_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .address(address),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit [31:0] ram [bit [31:0]];
  bit [7:0]  mbytes [bit [31:0]];
  bit rand_wait = 0, force_wait = 0, mon_en = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v |= 32'(mbytes[a + 32'(i)]) << (8 * i);
    if (n < 4 && sg && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) mbytes[a + 32'(i)] = wd[8*i +: 8];
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    return 4'(((1 << nbytes(sz)) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = nbytes(sz);
    if (n == 4) return wd;
    return (wd & ((32'd1 << (8 * n)) - 32'd1)) << (8 * a[1:0]);
  endfunction

  // word RAM responder with registered readdata
  initial forever begin
    @(posedge clk);
    if (!reset && !waitrequest) begin
      if (read) readdata = ram[address];
      if (write) begin
        bit [31:0] t;
        t = ram[address];
        for (int b = 0; b < 4; b++) if (byteenable[b]) t[8*b +: 8] = writedata[8*b +: 8];
        ram[address] = t;
      end
    end
  end

  // waitrequest generator and bus stability monitor
  initial begin
    logic p_rd, p_wr, stalled;
    logic [31:0] p_addr, p_wd;
    logic [3:0] p_be;
    stalled = 0; p_rd = 0; p_wr = 0; p_addr = 0; p_wd = 0; p_be = 0;
    forever begin
      @(negedge clk);
      if (mon_en && stalled) begin
        chk("stall_read", read, p_rd);
        chk("stall_write", write, p_wr);
        chk("stall_addr", address, p_addr);
        chk("stall_be", byteenable, p_be);
        chk("stall_wdata", writedata, p_wd);
      end
      if (read || write) chk("rw_excl", read & write, 0);
      p_rd = read; p_wr = write; p_addr = address; p_be = byteenable; p_wd = writedata;
      waitrequest = force_wait ? 1'b1 : (rand_wait ? 1'($urandom_range(0, 1)) : 1'b0);
      stalled = mon_en && !reset && (read || write) && waitrequest;
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic seen, output logic s_wr, output logic [31:0] s_addr,
                        output logic [3:0] s_be, output logic [31:0] s_wd);
    int guard;
    rd = 0; er = 0; lat = 0; seen = 0; s_wr = 0; s_addr = 0; s_be = 0; s_wd = 0;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("req_ready", req_ready, 1);
    req_valid = 1; req_write = wr; req_size = mem_size_t'(sz);
    req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
    do begin
      @(negedge clk);
      lat++;
      if ((read || write) && !seen) begin
        seen = 1; s_wr = write; s_addr = address; s_be = byteenable; s_wd = writedata;
      end
    end while (!resp_valid && lat < 200);
    chk("resp_seen", resp_valid, 1);
    rd = resp_rdata; er = resp_error;
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
  endtask

  initial begin
    logic [31:0] rd, s_addr, s_wd, a, wd, w1;
    logic er, seen, s_wr, wr, sg;
    logic [3:0] s_be;
    logic [1:0] sz;
    int lat;

    for (int w = 0; w < 16; w++) begin
      bit [31:0] v;
      v = (w == 0) ? 32'h44832211 : $urandom;
      ram[BASE + 32'(4 * w)] = v;
      for (int b = 0; b < 4; b++) mbytes[BASE + 32'(4 * w + b)] = v[8*b +: 8];
    end
    w1 = ram[BASE + 4];

    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rw", {read, write}, 0);
    chk("rst_resp", {resp_valid, resp_error}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_addr", address, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_wdata", writedata, 0);

    do_req(0, 2, 0, BASE, 0, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    chk("lw_data", rd, 32'h44832211);
    chk("lw_lat", lat, 3);
    chk("lw_strobe", {seen, s_wr}, 2'b10);
    chk("lw_addr", s_addr, BASE);
    chk("lw_be", s_be, 4'hF);
    chk("lw_err", er, 0);

    do_req(0, 0, 1, BASE + 2, 0, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    chk("lb_data", rd, 32'hFFFFFF83);
    chk("lb_be", s_be, 4'b0100);
    do_req(0, 0, 0, BASE + 2, 0, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    chk("lbu_data", rd, 32'h00000083);
    do_req(0, 1, 1, BASE + 2, 0, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    chk("lh_data", rd, 32'h00004483);

    do_req(1, 1, 0, BASE + 6, 32'h1234BEEF, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    model_store(1, BASE + 6, 32'h1234BEEF);
    chk("sh_strobe", {seen, s_wr}, 2'b11);
    chk("sh_addr", s_addr, BASE + 4);
    chk("sh_be", s_be, 4'b1100);
    chk("sh_wdata", s_wd, 32'hBEEF0000);
    chk("sh_lat", lat, 2);
    chk("sh_rdata", rd, 0);
    do_req(0, 2, 0, BASE + 4, 0, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    chk("sh_lw_hi", rd[31:16], 32'h0000BEEF);
    chk("sh_lw_lo", rd[15:0], w1[15:0]);

    do_req(0, 2, 0, BASE + 1, 0, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    chk("mis_lw", {er, 31'd0}, 32'h80000000);
    chk("mis_lw_rdata", rd, 0);
    chk("mis_lw_lat", lat, 1);
    chk("mis_lw_bus", seen, 0);
    do_req(0, 1, 1, BASE + 3, 0, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    chk("mis_lh", er, 1);
    chk("mis_lh_rdata", rd, 0);
    chk("mis_lh_lat", lat, 1);
    chk("mis_lh_bus", seen, 0);

    rand_wait = 1;
    for (int k = 0; k < 200; k++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      a  = BASE + 32'(4 * $urandom_range(0, 15));
      if (sz == 0) a += 32'($urandom_range(0, 3));
      else if (sz == 1) a += 32'(2 * $urandom_range(0, 1));
      do_req(wr, sz, sg, a, wd, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
      chk("rnd_err", er, 0);
      chk("rnd_strobe", {seen, s_wr}, {1'b1, wr});
      chk("rnd_addr", s_addr, a & 32'hFFFFFFFC);
      chk("rnd_be", s_be, exp_be(sz, a));
      if (wr) begin
        chk("rnd_wdata", s_wd, exp_wd(sz, a, wd));
        chk("rnd_st_rdata", rd, 0);
        model_store(sz, a, wd);
      end else begin
        chk("rnd_ld_rdata", rd, model_load(sz, sg, a));
      end
    end
    rand_wait = 0;

    @(negedge clk);
    force_wait = 1;
    req_valid = 1; req_write = 0; req_size = SIZE_WORD; req_signed = 0; req_addr = BASE + 8;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rst_mid_busy", read, 1);
    mon_en = 0;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_read", read, 0);
    chk("rst_mid_idle", req_ready, 1);
    chk("rst_mid_resp", resp_valid, 0);
    reset = 0;
    force_wait = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_noresp", resp_valid, 0);
    end
    mon_en = 1;
    do_req(0, 2, 0, BASE + 8, 0, rd, er, lat, seen, s_wr, s_addr, s_be, s_wd);
    chk("post_rst_lw", rd, model_load(2, 0, BASE + 8));
    chk("post_rst_lat", lat, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
